// File: rtl/tt_sel_seq.sv
// tt_sel_seq -- design-select strobe sequencer.
//
// Turns one address request into the controller's select sequence:
// disable, select-counter reset pulse, recovery, N increment pulses,
// then the final enable. All three strobes come straight from flops.
//
// Optional feature: define TT_SEL_SEQ_SHORTCUT_EN to count upward from the
// currently selected address, without a reset, when that is possible.
//
// Ports:
//   clk        system clock, rising edge
//   rst_n      asynchronous active-low reset
//   req_valid  request present
//   req_ready  high only while idle; accept = req_valid & req_ready
//   req_addr   target user-module address, captured on accept
//   req_ena    final enable value, captured on accept
//   busy       inverse of req_ready
//   cur_addr   address currently selected in the controller
//   cur_valid  cur_addr is known to match the controller counter
//   sel_rst_n  controller select-counter reset (active-low)
//   sel_inc    controller select-counter increment
//   ena        controller enable
module tt_sel_seq #(
    parameter int AW        = 10,
    parameter int RST_CYC   = 4,
    parameter int PULSE_CYC = 2
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          req_valid,
    output logic          req_ready,
    input  logic [AW-1:0] req_addr,
    input  logic          req_ena,
    output logic          busy,
    output logic [AW-1:0] cur_addr,
    output logic          cur_valid,
    output logic          sel_rst_n,
    output logic          sel_inc,
    output logic          ena
);

    localparam int MAX_CYC = (RST_CYC > PULSE_CYC) ? RST_CYC : PULSE_CYC;
    localparam int CW      = $clog2(MAX_CYC) + 1;
    localparam logic [CW-1:0] RST_LD   = CW'(RST_CYC - 1);
    localparam logic [CW-1:0] PULSE_LD = CW'(PULSE_CYC - 1);

    typedef enum logic [2:0] {
        IDLE, DIS, RST, REC, INC_HI, INC_LO, FIN
    } state_t;

    state_t        state, state_nxt;
    logic [CW-1:0] cnt, cnt_nxt;
    logic [AW-1:0] n, n_nxt;
    logic [AW-1:0] tgt;
    logic          tgt_ena;
    logic          accept;
    logic          short_ok;
    logic [AW-1:0] short_n;

    assign req_ready = (state == IDLE);
    assign busy      = ~req_ready;
    assign accept    = req_valid & req_ready;

`ifdef TT_SEL_SEQ_SHORTCUT_EN
    // Counting up from the known current address reaches the target
    // without a counter reset; going down is impossible, so that needs one.
    assign short_ok = cur_valid && (tgt >= cur_addr);
    assign short_n  = tgt - cur_addr;
`else
    assign short_ok = 1'b0;
    assign short_n  = '0;
`endif

    // Next-state logic; cnt holds remaining cycles-1 of the current phase.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        n_nxt     = n;
        case (state)
            IDLE: begin
                if (accept) state_nxt = DIS;
            end
            DIS: begin
                if (short_ok) begin
                    n_nxt = short_n;
                    if (short_n == '0) begin
                        state_nxt = FIN;
                    end else begin
                        state_nxt = INC_HI;
                        cnt_nxt   = PULSE_LD;
                    end
                end else begin
                    n_nxt     = tgt;
                    state_nxt = RST;
                    cnt_nxt   = RST_LD;
                end
            end
            RST: begin
                if (cnt == '0) begin
                    state_nxt = REC;
                    cnt_nxt   = PULSE_LD;
                end else begin
                    cnt_nxt = cnt - CW'(1);
                end
            end
            REC, INC_LO: begin
                if (cnt == '0) begin
                    if (n != '0) begin
                        state_nxt = INC_HI;
                        cnt_nxt   = PULSE_LD;
                    end else begin
                        state_nxt = FIN;
                    end
                end else begin
                    cnt_nxt = cnt - CW'(1);
                end
            end
            INC_HI: begin
                if (cnt == '0) begin
                    state_nxt = INC_LO;
                    cnt_nxt   = PULSE_LD;
                    // The pulse just issued is accounted for during its low phase.
                    if (n != '0) n_nxt = n - AW'(1);
                end else begin
                    cnt_nxt = cnt - CW'(1);
                end
            end
            FIN:     state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            cnt       <= '0;
            n         <= '0;
            tgt       <= '0;
            tgt_ena   <= 1'b0;
            sel_rst_n <= 1'b1;
            sel_inc   <= 1'b0;
            ena       <= 1'b0;
            cur_addr  <= '0;
            cur_valid <= 1'b0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            n     <= n_nxt;
            if (accept) begin
                tgt     <= req_addr;
                tgt_ena <= req_ena;
            end
            // Strobes are decoded from the next state so each flop output
            // lines up exactly with the state it belongs to.
            sel_rst_n <= (state_nxt != RST);
            sel_inc   <= (state_nxt == INC_HI);
            if (state_nxt == DIS) begin
                ena <= 1'b0;
            end else if (state_nxt == FIN) begin
                ena       <= tgt_ena;
                cur_addr  <= tgt;
                cur_valid <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_tt_sel_seq.sv
module tb_tt_sel_seq;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       req_valid = 1'b0;
    logic       req_ready;
    logic [9:0] req_addr = '0;
    logic       req_ena = 1'b0;
    logic       busy;
    logic [9:0] cur_addr;
    logic       cur_valid;
    logic       sel_rst_n;
    logic       sel_inc;
    logic       ena;

    int checks = 0;
    int failures = 0;

    // Per-request observations, cycle 1 = first cycle after the accept edge.
    int r_rdy, r_rst_lo, r_rst_first, r_pulses, r_badw, r_ena_first, r_ena_at1;

    tt_sel_seq #(.AW(10), .RST_CYC(4), .PULSE_CYC(2)) dut (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
        .req_addr(req_addr), .req_ena(req_ena), .busy(busy), .cur_addr(cur_addr),
        .cur_valid(cur_valid), .sel_rst_n(sel_rst_n), .sel_inc(sel_inc), .ena(ena)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Issue one request at cycle 0 and watch strobes until req_ready returns.
    // glitch: present a different request while busy (cycles 1..4).
    // keep:   leave req_valid asserted when returning.
    task automatic do_req(input logic [9:0] a, input logic e, input bit glitch, input bit keep);
        int k;
        int hi_run, lo_run;
        logic prev_inc;
        r_rdy = -1; r_rst_lo = 0; r_rst_first = -1; r_pulses = 0; r_badw = 0;
        r_ena_first = -1; r_ena_at1 = -1;
        hi_run = 0; lo_run = 0; prev_inc = 1'b0;
        @(negedge clk);
        req_valid = 1'b1; req_addr = a; req_ena = e;
        k = 1;
        forever begin
            @(negedge clk);
            if (k == 1) r_ena_at1 = int'(ena);
            if (!sel_rst_n) begin
                r_rst_lo++;
                if (r_rst_first < 0) r_rst_first = k;
            end
            if (sel_inc) begin
                if (!prev_inc) begin
                    r_pulses++;
                    if (r_pulses > 1 && lo_run != 2) r_badw++;
                end
                hi_run++;
                lo_run = 0;
            end else begin
                if (prev_inc && hi_run != 2) r_badw++;
                hi_run = 0;
                lo_run++;
            end
            prev_inc = sel_inc;
            if (ena && r_ena_first < 0) r_ena_first = k;
            if (req_ready) begin
                r_rdy = k;
                break;
            end
            if (k > 300) begin
                failures++;
                $error("FAIL timeout_ready observed=busy expected=ready");
                break;
            end
            if (glitch && k < 5) begin
                req_valid = 1'b1; req_addr = 10'd7; req_ena = 1'b0;
            end else if (!keep) begin
                req_valid = 1'b0;
            end
            k++;
        end
    endtask

    initial begin
        int t;
        // Reset state
        #12;
        chk("rst_sel_rst_n", int'(sel_rst_n), 1);
        chk("rst_sel_inc", int'(sel_inc), 0);
        chk("rst_ena", int'(ena), 0);
        chk("rst_cur_addr", int'(cur_addr), 0);
        chk("rst_cur_valid", int'(cur_valid), 0);
        chk("rst_ready", int'(req_ready), 1);
        chk("rst_busy", int'(busy), 0);
        @(negedge clk); rst_n = 1'b1;
        @(negedge clk);

        // Full path addr=3: 4 reset cycles, 3 pulses, ena at 20, ready at 21
        do_req(10'd3, 1'b1, 1'b0, 1'b0);
        chk("a3_rdy", r_rdy, 21);
        chk("a3_rst_lo", r_rst_lo, 4);
        chk("a3_rst_first", r_rst_first, 2);
        chk("a3_pulses", r_pulses, 3);
        chk("a3_widths", r_badw, 0);
        chk("a3_ena_first", r_ena_first, 20);
        chk("a3_ena_at1", r_ena_at1, 0);
        chk("a3_cur_addr", int'(cur_addr), 3);
        chk("a3_cur_valid", int'(cur_valid), 1);
        chk("a3_ena_end", int'(ena), 1);

        // 3 -> 5: upward shortcut when enabled
        do_req(10'd5, 1'b1, 1'b0, 1'b0);
`ifdef TT_SEL_SEQ_SHORTCUT_EN
        chk("a5_rdy", r_rdy, 11);
        chk("a5_rst_lo", r_rst_lo, 0);
        chk("a5_pulses", r_pulses, 2);
`else
        chk("a5_rdy", r_rdy, 29);
        chk("a5_rst_lo", r_rst_lo, 4);
        chk("a5_pulses", r_pulses, 5);
`endif
        chk("a5_widths", r_badw, 0);
        chk("a5_ena_at1", r_ena_at1, 0);
        chk("a5_ena_first", r_ena_first, r_rdy - 1);
        chk("a5_cur_addr", int'(cur_addr), 5);

        // 5 -> 2: going down always needs the full path
        do_req(10'd2, 1'b1, 1'b0, 1'b0);
        chk("a2_rdy", r_rdy, 17);
        chk("a2_rst_lo", r_rst_lo, 4);
        chk("a2_pulses", r_pulses, 2);
        chk("a2_cur_addr", int'(cur_addr), 2);

        // Same address again with ena=0
        do_req(10'd2, 1'b0, 1'b0, 1'b0);
`ifdef TT_SEL_SEQ_SHORTCUT_EN
        chk("same_rdy", r_rdy, 3);
        chk("same_rst_lo", r_rst_lo, 0);
        chk("same_pulses", r_pulses, 0);
`else
        chk("same_rdy", r_rdy, 17);
        chk("same_rst_lo", r_rst_lo, 4);
        chk("same_pulses", r_pulses, 2);
`endif
        chk("same_ena_at1", r_ena_at1, 0);
        chk("same_ena_first", r_ena_first, -1);
        chk("same_ena_end", int'(ena), 0);

        // Request 1 while a different request is presented during busy
        do_req(10'd1, 1'b1, 1'b1, 1'b0);
        chk("busy_rdy", r_rdy, 13);
        chk("busy_pulses", r_pulses, 1);
        chk("busy_cur_addr", int'(cur_addr), 1);
        chk("busy_ena_end", int'(ena), 1);

        // Request 0 held valid: full path (0 < 1), then re-accept at once
        do_req(10'd0, 1'b1, 1'b0, 1'b1);
        chk("a0_rdy", r_rdy, 9);
        chk("a0_pulses", r_pulses, 0);
        chk("a0_rst_lo", r_rst_lo, 4);
        @(negedge clk);
        chk("b2b_busy", int'(busy), 1);
        req_valid = 1'b0;
        t = 0;
        while (!req_ready && t < 300) begin
            @(negedge clk);
            t++;
        end
        chk("b2b_done", int'(req_ready), 1);
        chk("b2b_cur_addr", int'(cur_addr), 0);
        chk("b2b_ena", int'(ena), 1);

        // Async reset while sel_inc is high
        @(negedge clk);
        req_valid = 1'b1; req_addr = 10'd4; req_ena = 1'b1;
        @(negedge clk);
        req_valid = 1'b0;
        t = 0;
        while (!sel_inc && t < 300) begin
            @(negedge clk);
            t++;
        end
        chk("mid_inc_reached", int'(sel_inc), 1);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_sel_inc", int'(sel_inc), 0);
        chk("arst_ena", int'(ena), 0);
        chk("arst_cur_valid", int'(cur_valid), 0);
        chk("arst_sel_rst_n", int'(sel_rst_n), 1);
        chk("arst_ready", int'(req_ready), 1);
        @(negedge clk); rst_n = 1'b1;

        // After reset the next request must take the full path
        do_req(10'd4, 1'b1, 1'b0, 1'b0);
        chk("post_rdy", r_rdy, 25);
        chk("post_rst_lo", r_rst_lo, 4);
        chk("post_pulses", r_pulses, 4);
        chk("post_cur_addr", int'(cur_addr), 4);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/tt_sel_seq.md
# tt_sel_seq

On-chip selection sequencer that drives the controller's design-select strobes (`sel_rst_n`, `sel_inc`, `ena`) from a single address request. It replaces hand-toggled pad sequences. A requester presents a target user-module address with a valid/ready handshake. The block then generates the reset pulse, the increment pulse train and the final enable, with guaranteed pulse widths. It sits between the management/config logic and the controller's `ctrl_sel_rst_n` / `ctrl_sel_inc` / `ctrl_ena` inputs.

## Interface
Parameters:
- `AW`, 10: width of the user-module address (branch + column).
- `RST_CYC`, 4: cycles `sel_rst_n` is held low (≥1).
- `PULSE_CYC`, 2: cycles per high phase and per low phase of each `sel_inc` pulse, and the recovery time after reset (≥1).

Ports:
- `clk`  in  1  system clock; all state changes on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `req_valid`  in  1  request present.
- `req_ready`  out  1  high only in IDLE; a request is accepted on an edge where `req_valid & req_ready`.
- `req_addr`  in  AW  target address, captured on accept.
- `req_ena`  in  1  value `ena` takes once selection completes, captured on accept.
- `busy`  out  1  equals `~req_ready`.
- `cur_addr`  out  AW  address currently selected in the controller.
- `cur_valid`  out  1  `cur_addr` is known to match the controller counter.
- `sel_rst_n`  out  1  to the controller's select-counter reset, active-low.
- `sel_inc`  out  1  to the controller's select-counter increment.
- `ena`  out  1  to the controller's enable.

## Operation
- Reset values: `sel_rst_n`=1, `sel_inc`=0, `ena`=0, `cur_addr`=0, `cur_valid`=0, state IDLE, so `req_ready`=1 and `busy`=0.
- All three strobe outputs are registered and glitch-free.
- States and what each does:
  - IDLE: wait for accept; outputs hold.
  - DIS: one cycle; `ena`←0.
  - RST: `RST_CYC` cycles; `sel_rst_n`=0.
  - REC: `PULSE_CYC` cycles; `sel_rst_n`=1.
  - INC_HI: `PULSE_CYC` cycles; `sel_inc`=1.
  - INC_LO: `PULSE_CYC` cycles; `sel_inc`=0; decrement the remaining count N.
  - FIN: one cycle; `ena`←captured `req_ena`, `cur_addr`←target, `cur_valid`←1.
- Transitions:
  - IDLE→DIS on accept.
  - DIS→RST on the full path, or DIS→INC_HI / FIN on the shortcut path (see Configuration).
  - RST→REC.
  - REC→INC_HI if N>0, else FIN.
  - INC_LO→INC_HI if N>0, else FIN.
  - FIN→IDLE.
- Full path: N = target.
- Phase counter is `$clog2(max(RST_CYC,PULSE_CYC))+1` bits. The N counter is AW bits, with no wrap: N is never decremented below 0.
- `req_valid` is ignored while busy; no queueing and no abort.
- `ena` is always low from DIS through the cycle before FIN, even when reselecting the same address.
- Async reset mid-sequence: all outputs go to reset values immediately. `cur_valid`=0 forces the next request onto the full path.

## Timing
- Accept edge = cycle 0.
- Full path: DIS at cycle 1, `sel_rst_n` low cycles 2..RST_CYC+1. `req_ready` returns high at cycle RST_CYC+3+PULSE_CYC·(1+2N).
- Shortcut path: `req_ready` returns high at cycle 3+2·PULSE_CYC·N.
- New `ena` is visible from FIN (one cycle before `req_ready`).
- Back-to-back: a request held valid is accepted on the first IDLE cycle. The minimum gap between accepts is 1 IDLE cycle.

## Configuration
- `TT_SEL_SEQ_SHORTCUT_EN` defined:
  - If `cur_valid` and target ≥ `cur_addr`: skip RST/REC and use N = target − `cur_addr`.
  - If additionally N=0: DIS→FIN.
  - If target < `cur_addr` or `!cur_valid`: full path.
- Undefined: the full path is always used, and `cur_addr`/`cur_valid` are informational only.

## Test plan
- Reset, then request addr=3, ena=1 (RST_CYC=4, PULSE_CYC=2) -> `sel_rst_n` low for exactly 4 cycles, 3 `sel_inc` pulses each 2 high/2 low, `ena`=1 at cycle 20, `req_ready` at cycle 21, `cur_addr`=3.
- Request addr=0, ena=1 from reset -> reset pulse, zero `sel_inc` pulses, `req_ready` at cycle 9.
- With SHORTCUT_EN, after addr=3 request addr=5 -> no `sel_rst_n` low, 2 pulses, `req_ready` at cycle 11; request addr=2 next -> full path with 2 pulses.
- With SHORTCUT_EN, re-request the same addr=5 with ena=0 -> `ena` low from cycle 1, no strobes, `req_ready` at cycle 3, `ena` stays 0.
- Assert `req_valid` with a different address while busy -> ignored, with no change to the captured target or pulse count.
- Assert `rst_n` low mid-INC_HI -> `sel_inc`=0, `ena`=0, `cur_valid`=0 immediately; the next request takes the full path even with SHORTCUT_EN.
